// File: rtl/posit_sum_round_es2.sv
// posit_sum_round_es2
//   Three-stage rounding/packing stage for the raw posit<8,2> adder sum.
//   Round-to-nearest-even on the wide fraction, renormalise on mantissa
//   carry-out, saturate the scale to +/-MAX_SCALE (never to zero), and pack
//   the result back into the serialized {sgn, scale, fraction, inf, zero}
//   format. A saturating counter tracks how many results were inexact.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-high
//   start          input valid (X treated as 0)
//   in_sum         {sgn, scale[SCALE_W], frac[SUM_FRAC_W], inf, zero}
//   in_truncated   upstream lost bits; folded into sticky
//   result         {sgn, scale[SCALE_W], frac[OUT_FRAC_W], inf, zero}
//   done           result valid, 3 cycles after start
//   inexact        result differs from exact sum (qualified by done)
//   inexact_count  saturating count of done & inexact cycles
module posit_sum_round_es2 #(
  parameter int SUM_FRAC_W = 30,
  parameter int OUT_FRAC_W = 27,
  parameter int SCALE_W    = 8,
  parameter int MAX_SCALE  = 24,
  parameter int CNT_W      = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [SCALE_W+SUM_FRAC_W+2:0]   in_sum,
  input  logic                            in_truncated,
  output logic [SCALE_W+OUT_FRAC_W+2:0]   result,
  output logic                            done,
  output logic                            inexact,
  output logic [CNT_W-1:0]                inexact_count
);

  localparam int D  = SUM_FRAC_W - OUT_FRAC_W;
  localparam int OW = SCALE_W + OUT_FRAC_W + 3;
  localparam logic signed [SCALE_W:0] SMAX = (SCALE_W+1)'(MAX_SCALE);
  localparam logic signed [SCALE_W:0] SMIN = -SMAX;

  // ---------------- input unpack / rounding decision ----------------
  logic                  in_sgn, in_inf, in_zero;
  logic [SCALE_W-1:0]    in_scale;
  logic [SUM_FRAC_W-1:0] in_frac;
  logic [OUT_FRAC_W-1:0] kept;
  logic                  guard, sticky, start_v;

  assign {in_sgn, in_scale, in_frac, in_inf, in_zero} = in_sum;
  assign kept    = in_frac[SUM_FRAC_W-1:D];
  assign guard   = in_frac[D-1];
  // case-equality so an unknown start behaves as a bubble
  assign start_v = (start === 1'b1);

  generate
    if (D > 1) begin : g_sticky
      assign sticky = (|in_frac[D-2:0]) | in_truncated;
    end else begin : g_sticky_trunc
      assign sticky = in_truncated;
    end
  endgenerate

  // ---------------- stage 1: registered inputs ----------------
  logic                  s1_vld_q, s1_sgn_q, s1_up_q, s1_inex_q, s1_inf_q, s1_zero_q;
  logic [SCALE_W-1:0]    s1_scale_q;
  logic [OUT_FRAC_W-1:0] s1_kept_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_vld_q   <= 1'b0;
      s1_sgn_q   <= 1'b0;
      s1_scale_q <= '0;
      s1_kept_q  <= '0;
      s1_up_q    <= 1'b0;
      s1_inex_q  <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
    end else begin
      s1_vld_q   <= start_v;
      s1_sgn_q   <= in_sgn;
      s1_scale_q <= in_scale;
      s1_kept_q  <= kept;
      s1_up_q    <= guard & (sticky | kept[0]);
      s1_inex_q  <= guard | sticky;
      s1_inf_q   <= in_inf;
      s1_zero_q  <= in_zero;
    end
  end

  // ---------------- stage 2: increment / renormalise ----------------
  logic [OUT_FRAC_W:0]       s2_sum;
  logic                      s2_carry;
  logic signed [SCALE_W:0]   s2_scale_d;
  logic [OUT_FRAC_W-1:0]     s2_frac_d;

  assign s2_sum   = {1'b0, s1_kept_q} + (OUT_FRAC_W+1)'(s1_up_q);
  assign s2_carry = s2_sum[OUT_FRAC_W];
  // one extra scale bit so +127 + carry cannot wrap before saturation
  assign s2_scale_d = $signed({s1_scale_q[SCALE_W-1], s1_scale_q})
                    + $signed({{SCALE_W{1'b0}}, s2_carry});
  // carry-out means 1.111..1 rounded to 10.000..0: fraction becomes 0
  assign s2_frac_d  = s2_carry ? '0 : s2_sum[OUT_FRAC_W-1:0];

  logic                      s2_vld_q, s2_sgn_q, s2_inex_q, s2_inf_q, s2_zero_q;
  logic signed [SCALE_W:0]   s2_scale_q;
  logic [OUT_FRAC_W-1:0]     s2_frac_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_vld_q   <= 1'b0;
      s2_sgn_q   <= 1'b0;
      s2_scale_q <= '0;
      s2_frac_q  <= '0;
      s2_inex_q  <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
    end else begin
      s2_vld_q   <= s1_vld_q;
      s2_sgn_q   <= s1_sgn_q;
      s2_scale_q <= s2_scale_d;
      s2_frac_q  <= s2_frac_d;
      s2_inex_q  <= s1_inex_q;
      s2_inf_q   <= s1_inf_q;
      s2_zero_q  <= s1_zero_q;
    end
  end

  // ---------------- stage 3: saturate, specials, output ----------------
  logic [OW-1:0] result_d;
  logic          inexact_d;

  always_comb begin
    result_d  = {s2_sgn_q, s2_scale_q[SCALE_W-1:0], s2_frac_q, 2'b00};
    inexact_d = s2_inex_q;
    if (s2_inf_q) begin
      result_d  = OW'(2);
      inexact_d = 1'b0;
    end else if (s2_zero_q) begin
      result_d  = OW'(1);
      inexact_d = 1'b0;
    end else if (s2_scale_q > SMAX) begin
      result_d  = {s2_sgn_q, SMAX[SCALE_W-1:0], {OUT_FRAC_W{1'b0}}, 2'b00};
      inexact_d = 1'b1;
    end else if (s2_scale_q < SMIN) begin
      // clamp to minpos magnitude; a nonzero sum never becomes zero
      result_d  = {s2_sgn_q, SMIN[SCALE_W-1:0], {OUT_FRAC_W{1'b0}}, 2'b00};
      inexact_d = 1'b1;
    end
  end

  logic [OW-1:0]    result_q;
  logic             done_q, inexact_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q  <= '0;
      done_q    <= 1'b0;
      inexact_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      done_q <= s2_vld_q;
      // bubbles leave the last result in place
      if (s2_vld_q) begin
        result_q  <= result_d;
        inexact_q <= inexact_d;
        if (inexact_d && (cnt_q != {CNT_W{1'b1}}))
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign result        = result_q;
  assign done          = done_q;
  assign inexact       = inexact_q;
  assign inexact_count = cnt_q;

endmodule

// File: tb/tb_posit_sum_round_es2.sv
module tb_posit_sum_round_es2;
  localparam int SF = 30, OF = 27, SW = 8, MS = 24;
  localparam int D  = SF - OF;
  localparam int IW = SW + SF + 3;
  localparam int OW = SW + OF + 3;

  logic          clk = 1'b0;
  logic          reset, start, trunc;
  logic [IW-1:0] in_sum;
  logic [OW-1:0] result, result4;
  logic          done, inexact, done4, inexact4;
  logic [15:0]   cnt_o;
  logic [3:0]    cnt4_o;

  always #5 clk = ~clk;

  posit_sum_round_es2 dut (
    .clk(clk), .reset(reset), .start(start), .in_sum(in_sum), .in_truncated(trunc),
    .result(result), .done(done), .inexact(inexact), .inexact_count(cnt_o));

  posit_sum_round_es2 #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .in_sum(in_sum), .in_truncated(trunc),
    .result(result4), .done(done4), .inexact(inexact4), .inexact_count(cnt4_o));

  typedef struct { bit v; logic [OW-1:0] r; bit ix; } exp_t;
  exp_t pend[$];

  int total = 0, bad = 0;
  int cnt16 = 0, cnt4 = 0;
  logic [OW-1:0] last_res = '0;
  bit last_done;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued rounding of the wide fraction to OF bits.
  function automatic void model(input logic [IW-1:0] s, input logic tr,
                                output logic [OW-1:0] r, output bit ix);
    logic sg, inf, zr;
    logic [SW-1:0] scb;
    logic [SF-1:0] fb;
    longint f, q, rem, half;
    int sc;
    bit up;
    {sg, scb, fb, inf, zr} = s;
    f    = longint'(fb);
    half = longint'(1) << (D - 1);
    q    = f >> D;
    rem  = f - (q << D);
    up   = (rem > half) || (rem == half && (tr === 1'b1 || (q % 2) == 1));
    ix   = (rem != 0) || (tr === 1'b1);
    q    = q + (up ? 1 : 0);
    sc   = int'($signed(scb));
    if (q == (longint'(1) << OF)) begin q = 0; sc++; end
    if (sc > MS)       begin sc = MS;  q = 0; ix = 1; end
    else if (sc < -MS) begin sc = -MS; q = 0; ix = 1; end
    r = {sg, SW'(sc), OF'(q), 2'b00};
    if (inf)     begin r = OW'(2); ix = 0; end
    else if (zr) begin r = OW'(1); ix = 0; end
  endfunction

  task automatic step(input logic st, input logic sg, input int sc, input longint fr,
                      input bit tr, input bit inf, input bit zr);
    exp_t e;
    logic [OW-1:0] er;
    bit ex;
    start  = st;
    trunc  = tr;
    in_sum = {sg, SW'(sc), SF'(fr), inf, zr};
    model(in_sum, trunc, er, ex);
    e.v = (st === 1'b1); e.r = er; e.ix = ex;
    pend.push_back(e);
    @(posedge clk); #1;
    if (pend.size() >= 3) begin
      e = pend.pop_front();
      chk("done", done, e.v);
      chk("done4", done4, e.v);
      if (e.v) begin
        chk("result", result, e.r);
        chk("result4", result4, e.r);
        chk("inexact", inexact, e.ix);
        chk("inexact4", inexact4, e.ix);
        last_res = e.r;
        if (e.ix) begin
          if (cnt16 < 65535) cnt16++;
          if (cnt4 < 15) cnt4++;
        end
      end
    end else begin
      chk("done_fill", done, 1'b0);
    end
    chk("result_hold", result, last_res);
    chk("count", cnt_o, cnt16);
    chk("count4", cnt4_o, cnt4);
    last_done = done;
  endtask

  task automatic bubble();
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse(input logic sg, input int sc, input longint fr,
                       input bit tr, input bit inf, input bit zr);
    step(1'b1, sg, sc, fr, tr, inf, zr);
    bubble();
    bubble();
  endtask

  task automatic fld(input string tag, input logic [SW-1:0] sc, input logic [OF-1:0] fr,
                     input bit ix);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_scale"}, result[OW-2 -: SW], sc);
    chk({tag, "_frac"}, result[OF+1:2], fr);
    chk({tag, "_inexact"}, inexact, ix);
  endtask

  task automatic do_reset();
    start = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst_done", done, 1'b0);
    chk("rst_result", result, '0);
    chk("rst_inexact", inexact, 1'b0);
    chk("rst_count", cnt_o, 0);
    chk("rst_count4", cnt4_o, 0);
    pend.delete();
    cnt16 = 0; cnt4 = 0; last_res = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    bit seq [9];
    logic [6:0] pat;
    reset = 1'b1; start = 1'b0; trunc = 1'b0; in_sum = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // rounding cases
    pulse(0, 3, (27'h1 << 3) | 3'b100, 0, 0, 0);
    fld("round_up", 8'd3, 27'h2, 1);
    chk("round_up_cnt", cnt_o, 1);
    pulse(0, 3, (27'h2 << 3) | 3'b100, 0, 0, 0);
    fld("tie_even", 8'd3, 27'h2, 1);
    pulse(0, 3, (27'h2 << 3) | 3'b100, 1, 0, 0);
    fld("tie_sticky", 8'd3, 27'h3, 1);
    pulse(1, 5, 30'h3FFFFFFF, 0, 0, 0);
    fld("carry", 8'd6, 27'h0, 1);
    chk("carry_sign", result[OW-1], 1'b1);
    pulse(0, 3, 27'h5 << 3, 0, 0, 0);
    fld("exact", 8'd3, 27'h5, 0);
    chk("exact_cnt", cnt_o, 4);

    // saturation and specials
    pulse(0, 30, 30'h1234567, 0, 0, 0);
    fld("sat_hi", 8'd24, 27'h0, 1);
    pulse(1, -30, 30'h0, 0, 0, 0);
    fld("sat_lo", 8'hE8, 27'h0, 1);
    pulse(1, 7, 30'h3FFFFFFF, 1, 1, 1);
    chk("inf_prio", result, OW'(2));
    chk("inf_inexact", inexact, 1'b0);
    pulse(1, 7, 30'h3FFFFFFF, 1, 0, 1);
    chk("zero", result, OW'(1));
    chk("zero_inexact", inexact, 1'b0);
    pulse(0, 127, 30'h3FFFFFFF, 0, 0, 0);
    fld("no_wrap", 8'd24, 27'h0, 1);

    // unknown start behaves as a bubble
    step(1'bx, 0, 1, 30'h7, 0, 0, 0);
    bubble(); bubble();
    chk("x_start", done, 1'b0);

    // streaming: 5 starts, bubble, 2 starts
    do_reset();
    seq = '{1, 1, 1, 1, 1, 0, 1, 1, 0};
    pat = '0;
    for (int i = 0; i < 9; i++) begin
      step(seq[i], 1'($urandom), $urandom_range(0, 40) - 20, longint'($urandom) & 30'h3FFFFFFF,
           1'($urandom), 0, 0);
      if (i >= 2) pat = {pat[5:0], last_done};
    end
    chk("stream_pat", pat, 7'b1111101);

    // reset with two results in flight
    do_reset();
    step(1, 0, 2, 30'h5, 1, 0, 0);
    step(1, 0, 2, 30'h6, 1, 0, 0);
    do_reset();
    repeat (4) bubble();
    pulse(0, 2, 30'h6, 1, 0, 0);
    chk("after_rst_done", done, 1'b1);
    chk("after_rst_cnt", cnt_o, 1);

    // counter saturation on the narrow instance
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1, 1'($urandom), $urandom_range(0, 20), (longint'($urandom) & 30'h3FFFFFF8) | 1, 0, 0, 0);
    bubble(); bubble();
    chk("cnt4_sat", cnt4_o, 4'hF);
    chk("cnt16_20", cnt_o, 20);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int sc;
      sc = ($urandom_range(0, 3) == 0) ? int'($signed(8'($urandom))) : $urandom_range(0, 60) - 30;
      step(($urandom_range(0, 4) != 0), 1'($urandom), sc,
           ($urandom_range(0, 7) == 0) ? 30'h3FFFFFFF : (longint'($urandom) & 30'h3FFFFFFF),
           1'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end
    bubble(); bubble(); bubble();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
